rpc_net_tx_serializer: RTL and testbench
========================================

Name: rpc_net_tx_serializer

Overview:
- Network-side consumer of the RPC unit's TX packet output. It accepts one wide packet per valid cycle; that source has no backpressure.
- Packets are buffered in a small packet FIFO, then emitted as a narrow beat stream with valid/ready, sop/eop and byte-keep toward the transport/MAC.
- It is the receiving end of the RPC unit's network_tx interface and converts a single-cycle wide transfer into a flow-controlled stream.

Parameters:
- NIC_ID, 32'h0, instance id used in simulation $display messages only.
- PAYLOAD_W, 512, payload bit width of the input packet.
- BEAT_W, 64, output beat width in bits; must divide PAYLOAD_W and be a multiple of 8.
- CONN_W, 16, connection id width.
- SIZE_W, 16, payload_size field width, in bytes.
- FIFO_DEPTH, 4, packet FIFO depth; must be a power of 2, >= 2.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- pkt_valid_in  in  1  input packet valid; single-cycle, no ready
- pkt_conn_id_in  in  CONN_W  connection id
- pkt_size_in  in  SIZE_W  payload length in bytes
- pkt_payload_in  in  PAYLOAD_W  payload, byte 0 at bits [7:0]
- beat_valid_out  out  1  beat valid
- beat_ready_in  in  1  downstream ready
- beat_data_out  out  BEAT_W  beat data
- beat_keep_out  out  BEAT_W/8  byte enables
- beat_sop_out  out  1  first beat of packet
- beat_eop_out  out  1  last beat of packet
- beat_conn_id_out  out  CONN_W  conn id, held for the whole packet
- drop_cnt_out  out  32  saturating count of discarded packets
- fifo_level_out  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset values: every output 0. FIFO is emptied, FSM goes to IDLE, beat index is 0, drop_cnt is 0. Reset mid-packet aborts the packet; no eop is emitted and it is not resumed.
- Let BB = BEAT_W/8 and MAXB = PAYLOAD_W/8.
- Admission:
  - A packet with pkt_size_in == 0 or pkt_size_in > MAXB is discarded and drop_cnt increments.
  - A valid packet is pushed if level < FIFO_DEPTH, or if a pop occurs in the same cycle (the pop frees the slot). Otherwise it is discarded and drop_cnt increments.
  - drop_cnt saturates at 32'hFFFF_FFFF.
- FIFO stores {conn_id, size, payload}. fifo_level_out is registered and reflects push/pop of the previous edge.
- FSM has two states, IDLE and SEND.
- IDLE:
  - If FIFO is non-empty: pop the head into the packet shadow register, set beat index to 0, go to SEND.
  - Latency: pkt_valid_in at cycle N, with FIFO empty and FSM idle, gives beat_valid_out at cycle N+2.
- SEND:
  - beat_valid_out = 1.
  - beat_data_out = shadow_payload[idx*BEAT_W +: BEAT_W].
  - nbeats = ceil(size/BB). last = (idx == nbeats-1).
  - beat_sop_out = (idx == 0). beat_eop_out = last.
  - beat_keep_out is all ones, except on the last beat it is the lower (size mod BB) bits set (all ones if the remainder is 0).
  - Bytes beyond size in the last beat are driven as stored; downstream must ignore them via keep.
- Handshake (AXI-stream rules):
  - A transfer occurs when beat_valid_out && beat_ready_in.
  - While valid && !ready, data, keep, sop, eop and conn_id are held stable.
  - valid never drops without a transfer, except on reset.
- On a transfer:
  - Not last: idx increments.
  - Last with FIFO non-empty: pop the next packet into the shadow register in the same cycle and stay in SEND with idx = 0. There is no bubble between packets.
  - Last with FIFO empty: go to IDLE, and beat_valid_out is 0 the next cycle.
- A push and a pop on the same cycle leave level unchanged. A push into an empty FIFO while in IDLE is popped the following cycle.
- The FIFO read pointer wraps modulo FIFO_DEPTH, with no lost or duplicated entries across the wrap.
- In simulation, $display is issued on each accept and each drop, tagged with NIC_ID.

Test Plan:
Defaults are PAYLOAD_W=512, BEAT_W=64, FIFO_DEPTH=4, ready=1 unless noted.
1. Single packet: size=20, conn=5, payload byte k = k, pulsed at cycle 0 -> 3 beats at cycles 2,3,4.
   - beat0 data=64'h0706050403020100, sop=1, keep=8'hFF.
   - beat2 eop=1, keep=8'h0F.
   - conn_id=5 on all beats.
   - drop_cnt=0.
2. Backpressure: same packet, beat_ready_in=0 for 3 cycles while beat1 is presented -> beat1 data=64'h0F0E0D0C0B0A0908 held unchanged for 4 cycles, then the stream completes normally.
3. Overflow: ready=0, 6 valid packets (size=8) on consecutive cycles -> 5 accepted (4 in FIFO after 1 popped to shadow), fifo_level=4, drop_cnt=1. After ready=1, exactly 5 single-beat packets with sop=eop=1 are emitted in order.
4. Bad size: size=0 then size=65 -> no beats, drop_cnt=2, fifo_level stays 0.
5. Back-to-back: packets of size 8 and size 64 pulsed on consecutive cycles -> 1 beat (sop=eop=1, keep=FF) immediately followed by 8 beats with no idle cycle. Only the 8th beat of the second packet has eop=1.
6. Reset mid-packet: assert reset after beat1 of a 3-beat packet with 2 more queued -> next cycle valid=0, fifo_level=0, drop_cnt=0. No beats appear after reset deasserts until a new pkt_valid_in.

Source files
------------

// File: rtl/rpc_net_tx_serializer.sv
// Network-side TX serializer: buffers wide RPC packets in a small FIFO and
// streams them out as valid/ready beats with sop/eop and byte keep.
module rpc_net_tx_serializer #(
  parameter logic [31:0] NIC_ID     = 32'h0,
  parameter int          PAYLOAD_W  = 512,
  parameter int          BEAT_W     = 64,
  parameter int          CONN_W     = 16,
  parameter int          SIZE_W     = 16,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              pkt_valid_in,
  input  logic [CONN_W-1:0]                 pkt_conn_id_in,
  input  logic [SIZE_W-1:0]                 pkt_size_in,
  input  logic [PAYLOAD_W-1:0]              pkt_payload_in,
  output logic                              beat_valid_out,
  input  logic                              beat_ready_in,
  output logic [BEAT_W-1:0]                 beat_data_out,
  output logic [BEAT_W/8-1:0]               beat_keep_out,
  output logic                              beat_sop_out,
  output logic                              beat_eop_out,
  output logic [CONN_W-1:0]                 beat_conn_id_out,
  output logic [31:0]                       drop_cnt_out,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_level_out
);

  localparam int BB     = BEAT_W / 8;
  localparam int MAXB   = PAYLOAD_W / 8;
  localparam int NB_MAX = PAYLOAD_W / BEAT_W;
  localparam int IDX_W  = (NB_MAX > 1) ? $clog2(NB_MAX) : 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [CONN_W-1:0]    mem_conn    [FIFO_DEPTH];
  logic [SIZE_W-1:0]    mem_size    [FIFO_DEPTH];
  logic [PAYLOAD_W-1:0] mem_payload [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [LVL_W-1:0]     level;

  logic [0:0]           state;
  logic [IDX_W-1:0]     idx;
  logic [CONN_W-1:0]    sh_conn;
  logic [SIZE_W-1:0]    sh_size;
  logic [PAYLOAD_W-1:0] sh_payload;
  logic [BEAT_W-1:0]    sh_beats [NB_MAX];
  logic [31:0]          drop_cnt;

  logic              size_ok, fifo_empty, fifo_full, sending, xfer, is_last;
  logic              push, pop, drop;
  logic [SIZE_W-1:0] last_idx, rem;

  assign size_ok    = (pkt_size_in != '0) && (pkt_size_in <= SIZE_W'(MAXB));
  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == LVL_W'(FIFO_DEPTH));
  assign sending    = (state == ST_SEND);
  assign xfer       = sending && beat_ready_in;
  assign last_idx   = (sh_size - SIZE_W'(1)) / SIZE_W'(BB);
  assign rem        = sh_size % SIZE_W'(BB);
  assign is_last    = (SIZE_W'(idx) == last_idx);

  // A pop on the same edge frees a slot, so a full FIFO can still accept.
  assign pop  = !fifo_empty && (!sending || (xfer && is_last));
  assign push = pkt_valid_in && size_ok && (!fifo_full || pop);
  assign drop = pkt_valid_in && !push;

  always_comb begin
    for (int i = 0; i < NB_MAX; i++) sh_beats[i] = sh_payload[i*BEAT_W +: BEAT_W];
  end

  always_comb begin
    beat_keep_out = '0;
    if (sending) begin
      for (int b = 0; b < BB; b++)
        beat_keep_out[b] = !is_last || (rem == '0) || (SIZE_W'(b) < rem);
    end
  end

  assign beat_valid_out   = sending;
  assign beat_data_out    = sending ? sh_beats[idx] : '0;
  assign beat_sop_out     = sending && (idx == '0);
  assign beat_eop_out     = sending && is_last;
  assign beat_conn_id_out = sending ? sh_conn : '0;
  assign drop_cnt_out     = drop_cnt;
  assign fifo_level_out   = level;

  // Storage without reset; validity is tracked by pointers and state.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_conn[wr_ptr]    <= pkt_conn_id_in;
      mem_size[wr_ptr]    <= pkt_size_in;
      mem_payload[wr_ptr] <= pkt_payload_in;
    end
    if (pop) sh_payload <= mem_payload[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      state    <= ST_IDLE;
      idx      <= '0;
      sh_conn  <= '0;
      sh_size  <= '0;
      drop_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      level <= level + LVL_W'(1);
      else if (pop && !push) level <= level - LVL_W'(1);

      if (drop && (drop_cnt != 32'hFFFF_FFFF)) drop_cnt <= drop_cnt + 32'd1;

      if (pop) begin
        state   <= ST_SEND;
        idx     <= '0;
        sh_conn <= mem_conn[rd_ptr];
        sh_size <= mem_size[rd_ptr];
      end else if (xfer) begin
        if (is_last) state <= ST_IDLE;
        else         idx   <= idx + IDX_W'(1);
      end
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!reset && push) $display("nic %0h: accept conn=%0h size=%0d", NIC_ID, pkt_conn_id_in, pkt_size_in);
    if (!reset && drop) $display("nic %0h: drop conn=%0h size=%0d", NIC_ID, pkt_conn_id_in, pkt_size_in);
  end
`endif

endmodule

// File: tb/tb_rpc_net_tx_serializer.sv
// Randomized and directed bench for rpc_net_tx_serializer against a
// queue-based packet model; outputs are compared at every falling edge.
module tb_rpc_net_tx_serializer;

  logic         clk = 1'b0;
  logic         reset;
  logic         pkt_valid_in;
  logic [15:0]  pkt_conn_id_in;
  logic [15:0]  pkt_size_in;
  logic [511:0] pkt_payload_in;
  logic         beat_valid_out;
  logic         beat_ready_in;
  logic [63:0]  beat_data_out;
  logic [7:0]   beat_keep_out;
  logic         beat_sop_out;
  logic         beat_eop_out;
  logic [15:0]  beat_conn_id_out;
  logic [31:0]  drop_cnt_out;
  logic [2:0]   fifo_level_out;

  always #5 clk = ~clk;

  rpc_net_tx_serializer dut (
    .clk              (clk),
    .reset            (reset),
    .pkt_valid_in     (pkt_valid_in),
    .pkt_conn_id_in   (pkt_conn_id_in),
    .pkt_size_in      (pkt_size_in),
    .pkt_payload_in   (pkt_payload_in),
    .beat_valid_out   (beat_valid_out),
    .beat_ready_in    (beat_ready_in),
    .beat_data_out    (beat_data_out),
    .beat_keep_out    (beat_keep_out),
    .beat_sop_out     (beat_sop_out),
    .beat_eop_out     (beat_eop_out),
    .beat_conn_id_out (beat_conn_id_out),
    .drop_cnt_out     (drop_cnt_out),
    .fifo_level_out   (fifo_level_out)
  );

  typedef struct packed {
    logic [15:0]  conn;
    logic [15:0]  size;
    logic [511:0] pay;
  } pkt_t;

  int n_chk = 0;
  int n_bad = 0;

  // Model: queued packets, packet on the wire and which beat of it is shown.
  pkt_t        q[$];
  pkt_t        cur;
  bit          busy;
  int          k;
  logic [31:0] m_drop;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] pattern_pay();
    logic [511:0] p;
    for (int i = 0; i < 64; i++) p[i*8 +: 8] = 8'(i);
    return p;
  endfunction

  function automatic logic [511:0] rand_pay();
    logic [511:0] p;
    for (int i = 0; i < 16; i++) p[i*32 +: 32] = $urandom;
    return p;
  endfunction

  task automatic compare();
    int   nb, rem;
    logic [7:0] kp;
    chk("valid", 64'(beat_valid_out), 64'(busy));
    chk("level", 64'(fifo_level_out), 64'(q.size()));
    chk("drop", 64'(drop_cnt_out), 64'(m_drop));
    if (busy) begin
      nb  = (int'(cur.size) + 7) / 8;
      rem = int'(cur.size) % 8;
      kp  = (k == nb - 1 && rem != 0) ? 8'((1 << rem) - 1) : 8'hFF;
      chk("data", beat_data_out, cur.pay[k*64 +: 64]);
      chk("keep", 64'(beat_keep_out), 64'(kp));
      chk("sop", 64'(beat_sop_out), 64'(k == 0));
      chk("eop", 64'(beat_eop_out), 64'(k == nb - 1));
      chk("conn", 64'(beat_conn_id_out), 64'(cur.conn));
    end
  endtask

  task automatic step();
    int   nb;
    bit   last, pop, push;
    pkt_t np;
    if (reset) begin
      q.delete();
      busy   = 0;
      k      = 0;
      m_drop = '0;
      return;
    end
    nb   = (int'(cur.size) + 7) / 8;
    last = busy && beat_ready_in && (k == nb - 1);
    pop  = (q.size() > 0) && (!busy || last);
    push = pkt_valid_in && pkt_size_in != 0 && pkt_size_in <= 64 && (q.size() < 4 || pop);
    if (pkt_valid_in && !push && m_drop != 32'hFFFF_FFFF) m_drop++;
    if (pop) begin
      cur  = q.pop_front();
      busy = 1;
      k    = 0;
    end else if (last) busy = 0;
    else if (busy && beat_ready_in) k++;
    if (push) begin
      np.conn = pkt_conn_id_in;
      np.size = pkt_size_in;
      np.pay  = pkt_payload_in;
      q.push_back(np);
    end
  endtask

  task automatic cyc(input bit v, input logic [15:0] c, input logic [15:0] s,
                     input logic [511:0] p, input bit rdy, input bit rst);
    reset          = rst;
    pkt_valid_in   = v;
    pkt_conn_id_in = c;
    pkt_size_in    = s;
    pkt_payload_in = p;
    beat_ready_in  = rdy;
    step();
    @(negedge clk);
    compare();
  endtask

  task automatic idle(input bit rdy);
    cyc(0, 16'h0, 16'h0, '0, rdy, 0);
  endtask

  task automatic do_reset();
    cyc(0, 16'h0, 16'h0, '0, 1, 1);
    chk("rst_valid", 64'(beat_valid_out), 64'h0);
    chk("rst_data", beat_data_out, 64'h0);
    chk("rst_keep", 64'(beat_keep_out), 64'h0);
    chk("rst_sop", 64'(beat_sop_out), 64'h0);
    chk("rst_eop", 64'(beat_eop_out), 64'h0);
    chk("rst_conn", 64'(beat_conn_id_out), 64'h0);
    chk("rst_drop", 64'(drop_cnt_out), 64'h0);
    chk("rst_level", 64'(fifo_level_out), 64'h0);
  endtask

  initial begin
    reset = 1; pkt_valid_in = 0; pkt_conn_id_in = '0; pkt_size_in = '0;
    pkt_payload_in = '0; beat_ready_in = 1;
    q.delete(); busy = 0; k = 0; m_drop = '0; cur = '0;
    @(negedge clk);
    do_reset();
    do_reset();

    // single 20-byte packet, beats at cycles 2..4
    cyc(1, 16'd5, 16'd20, pattern_pay(), 1, 0);
    chk("t1_lat_c1", 64'(beat_valid_out), 64'h0);
    idle(1);
    chk("t1_b0_data", beat_data_out, 64'h0706050403020100);
    chk("t1_b0_sop", 64'(beat_sop_out), 64'h1);
    chk("t1_b0_keep", 64'(beat_keep_out), 64'hFF);
    idle(1);
    idle(1);
    chk("t1_b2_eop", 64'(beat_eop_out), 64'h1);
    chk("t1_b2_keep", 64'(beat_keep_out), 64'h0F);
    chk("t1_b2_conn", 64'(beat_conn_id_out), 64'd5);
    idle(1);
    chk("t1_done", 64'(beat_valid_out), 64'h0);
    chk("t1_drop", 64'(drop_cnt_out), 64'h0);

    // backpressure on beat1
    cyc(1, 16'd5, 16'd20, pattern_pay(), 1, 0);
    idle(1);
    idle(1);
    for (int i = 0; i < 3; i++) begin
      idle(0);
      chk("t2_hold", beat_data_out, 64'h0F0E0D0C0B0A0908);
    end
    for (int i = 0; i < 4; i++) idle(1);

    // overflow: six packets against a stalled sink
    do_reset();
    for (int i = 0; i < 6; i++) cyc(1, 16'(i + 1), 16'd8, rand_pay(), 0, 0);
    chk("t3_level", 64'(fifo_level_out), 64'd4);
    chk("t3_drop", 64'(drop_cnt_out), 64'd1);
    for (int i = 0; i < 8; i++) idle(1);

    // illegal sizes
    do_reset();
    cyc(1, 16'd1, 16'd0, rand_pay(), 1, 0);
    cyc(1, 16'd2, 16'd65, rand_pay(), 1, 0);
    idle(1);
    idle(1);
    chk("t4_drop", 64'(drop_cnt_out), 64'd2);
    chk("t4_level", 64'(fifo_level_out), 64'd0);

    // back-to-back 8 then 64 bytes
    cyc(1, 16'd3, 16'd8, rand_pay(), 1, 0);
    cyc(1, 16'd4, 16'd64, rand_pay(), 1, 0);
    for (int i = 0; i < 12; i++) idle(1);

    // reset mid-packet with two more queued
    cyc(1, 16'd7, 16'd20, rand_pay(), 1, 0);
    cyc(1, 16'd8, 16'd20, rand_pay(), 1, 0);
    cyc(1, 16'd9, 16'd20, rand_pay(), 1, 0);
    chk("t6_pre_sop", 64'(beat_sop_out), 64'h0);
    do_reset();
    for (int i = 0; i < 6; i++) idle(1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      else if ($urandom_range(0, 9) < 4)
        cyc(1, 16'($urandom), 16'($urandom_range(0, 72)), rand_pay(), $urandom_range(0, 9) < 7, 0);
      else
        idle($urandom_range(0, 9) < 7);
    end
    for (int i = 0; i < 60; i++) idle(1);
    chk("final_idle", 64'(beat_valid_out), 64'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
